result_framer: RTL and testbench
================================

# result_framer

Host-side reader for the vector output buffer and the reduce-ALU scalar path. On a `start` strobe from the controller, it drains the buffered result bytes from `out_bus` one at a time. It wraps them in a length-prefixed, checksummed frame and presents the frame as a valid/ready byte stream to the host transmitter. It is the consumer end of the `out_bus` / `out_count` interface and advances the output buffer with a one-cycle read strobe.

## Interface
Parameters:
- BITS, 8, byte width of `out_bus` and the stream; fixed at 8.
- N, 64, maximum vector length; must be ≤ 127 to fit the header length field.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to emit a frame; honoured only in IDLE.
- is_scalar  in  1  sampled with `start`: 1 = scalar result currently on `out_bus`, 0 = vector in output buffer.
- out_bus  in  BITS  current result byte: scalar value, or head element of the output buffer.
- out_count  in  32  number of bytes held in the output buffer.
- buff_rd  out  1  one-cycle pop strobe to the output buffer.
- tx_data  out  BITS  frame byte to the host transmitter.
- tx_valid  out  1  `tx_data` is valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the checksum byte is accepted.
- err  out  1  sticky: `out_count` exceeded N at `start`; cleared by the next accepted `start` or by `rst`.

## Operation
- Frame format:
  - HDR = {is_scalar, len[6:0]}.
  - `len` data bytes.
  - CSUM = two's complement of the 8-bit sum of HDR and all data bytes, so the whole frame sums to 0 mod 256.
- States: IDLE, HDR, DATA, CSUM.
- IDLE:
  - `start` latches `is_scalar`.
  - Scalar: latches `out_bus` into the scalar register, len = 1.
  - Vector: len = min(`out_count`, N); `err` is set if `out_count` > N, else cleared.
  - Running sum cleared to 0; next state HDR.
- HDR: `tx_data` = header byte. On handshake, sum += header; go to DATA if len > 0, else CSUM.
- DATA:
  - Scalar: `tx_data` = scalar register.
  - Vector: `tx_data` = `out_bus`, passed through combinationally, held stable because the buffer does not advance until the handshake.
  - On each handshake: sum += `tx_data`, remaining count decrements, and `buff_rd` pulses that same cycle (vector frames only). Go to CSUM after the last byte.
- CSUM: `tx_data` = (0 − sum) mod 256. On handshake go to IDLE and pulse `done` on the next cycle.
- Handshake rules:
  - A byte transfers when `tx_valid` && `tx_ready`.
  - `tx_valid` is never withdrawn, and `tx_data` never changes, before the transfer.
  - `tx_ready` may be low for any number of cycles.
- `start` while `busy` is ignored, with no queuing.
- Reset values: state IDLE; `tx_valid`, `buff_rd`, `busy`, `done`, `err` = 0; `tx_data` = 0; sum and count = 0.
- Reset mid-frame returns to IDLE at the next edge; the partial frame is abandoned and no further `buff_rd` is issued. Draining the buffer is the controller's job.

## Timing
- `start` at cycle T: `tx_valid` and `busy` high at T+1 with HDR.
- With `tx_ready` held high, a frame of len L takes L+2 cycles (T+1 … T+L+2).
- `done` is high at T+L+3 and `busy` is low at T+L+3.
- `buff_rd` coincides exactly with each accepted vector data byte; the buffer presents its next element on `out_bus` by the following cycle.
- `busy` rises the cycle after `start`.
- Back-to-back operation: a `start` in the `done` cycle is accepted.

## Structure
- Shared package `result_framer_pkg`:
  - state enum `frame_state_t` {IDLE, HDR, DATA, CSUM};
  - constant `HDR_SCALAR_BIT` = 7;
  - constant `LEN_W` = 7.
- One natural sub-module, `frame_checksum`: 8-bit accumulator with clear and add-enable that outputs the negated sum. Everything else is a single FSM file.

## Test plan
- Vector frame: `out_count` = 3, buffer holds 0x01, 0x02, 0x03, `tx_ready` = 1, `start` → stream 0x03, 0x01, 0x02, 0x03, 0xF7; exactly 3 `buff_rd` pulses; `done` at T+6.
- Scalar frame: `is_scalar` = 1, `out_bus` = 0x80 at `start`, `out_bus` changed to 0x55 afterwards → stream 0x81, 0x80, 0xFF; no `buff_rd`.
- Empty vector: `out_count` = 0 → stream 0x00, 0x00; no `buff_rd`; `done` at T+3.
- Backpressure: 3-byte vector with `tx_ready` toggling 1,0,0,1,… → same five bytes; `tx_data` stable while stalled; `buff_rd` only on accepted data bytes.
- Overflow: `out_count` = 70, N = 64 → header 0x40, 64 data bytes, `err` = 1; a following `start` with `out_count` = 2 clears `err`.
- Reset and busy: `rst` asserted during the second data byte → `tx_valid` = 0 and state IDLE at the next edge; `start` pulsed while `busy` produces no second frame.

Source files
------------

// File: rtl/result_framer_pkg.sv
// Shared definitions for the result framer: FSM state encoding and the
// header field layout (scalar flag in the top bit, length below it).
package result_framer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CSUM
  } frame_state_t;

  // Header byte layout: {is_scalar, len[6:0]}
  localparam int HDR_SCALAR_BIT = 7;
  localparam int LEN_W          = 7;

endpackage : result_framer_pkg

// File: rtl/result_framer_if.sv
// Byte stream from the framer to the host transmitter.
//   tx_data  : frame byte
//   tx_valid : tx_data holds a byte to be transferred
//   tx_ready : transmitter accepts the byte this cycle
// A byte moves when tx_valid && tx_ready.
interface result_framer_if #(
  parameter int BITS = 8
);

  logic [BITS-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;

  // Framer side drives data/valid.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side drives ready.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface : result_framer_if

// File: rtl/frame_checksum.sv
// Running 8-bit frame sum with clear and add-enable.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the running sum (start of a new frame)
//   add_en    : add add_data to the running sum this cycle
//   add_data  : byte being transferred
//   csum      : two's complement of the running sum, i.e. the byte that
//               makes the complete frame sum to zero mod 2^BITS
module frame_checksum #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            add_en,
  input  logic [BITS-1:0] add_data,
  output logic [BITS-1:0] csum
);

  logic [BITS-1:0] sum_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (add_en) begin
      sum_q <= sum_q + add_data;
    end
  end

  assign csum = BITS'(0) - sum_q;

endmodule : frame_checksum

// File: rtl/result_framer.sv
// Reads a scalar result or the vector output buffer and emits it to the host
// as a length-prefixed, checksummed byte frame: HDR, len data bytes, CSUM.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a frame (honoured only when idle)
//   is_scalar  : sampled with start; 1 = scalar on out_bus, 0 = vector buffer
//   out_bus    : scalar value or head element of the output buffer
//   out_count  : number of bytes held in the output buffer
//   buff_rd    : one-cycle pop strobe, coincident with each accepted vector byte
//   tx         : valid/ready byte stream to the host transmitter
//   busy       : frame in progress
//   done       : one-cycle pulse the cycle after the checksum byte is taken
//   err        : sticky, out_count exceeded N at the last accepted start
module result_framer
  import result_framer_pkg::*;
#(
  parameter int BITS = 8,
  parameter int N    = 64   // must fit in LEN_W bits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_scalar,
  input  logic [BITS-1:0]  out_bus,
  input  logic [31:0]      out_count,
  output logic             buff_rd,
  result_framer_if.master  tx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  frame_state_t     state_q, state_d;
  logic             is_scalar_q;
  logic [BITS-1:0]  scalar_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  logic             err_q;
  logic             done_q;

  logic             start_ok;
  logic             overflow;
  logic [LEN_W-1:0] start_len;
  logic [BITS-1:0]  hdr_byte;
  logic [BITS-1:0]  csum;
  logic             hs;
  logic             sum_add;
  logic             tx_valid_d;
  logic [BITS-1:0]  tx_data_d;
  logic             buff_rd_d;

  assign start_ok = (state_q == IDLE) && start;
  assign overflow = out_count > 32'(N);
  assign hs       = tx_valid_d && tx.tx_ready;

  // Frame length chosen at start: a scalar is always one byte; a vector is
  // clamped to N so the length fits the header field.
  always_comb begin
    if (is_scalar) begin
      start_len = LEN_W'(1);
    end else if (overflow) begin
      start_len = LEN_W'(N);
    end else begin
      start_len = out_count[LEN_W-1:0];
    end
  end

  always_comb begin
    hdr_byte                 = '0;
    hdr_byte[HDR_SCALAR_BIT] = is_scalar_q;
    hdr_byte[LEN_W-1:0]      = len_q;
  end

  frame_checksum #(.BITS(BITS)) u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .add_en   (sum_add),
    .add_data (tx_data_d),
    .csum     (csum)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    buff_rd_d  = 1'b0;
    sum_add    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = hdr_byte;
        if (hs) begin
          sum_add = 1'b1;
          state_d = (len_q != '0) ? DATA : CSUM;
        end
      end
      DATA: begin
        tx_valid_d = 1'b1;
        // The vector head is passed straight through; it stays stable
        // because the buffer only advances on our own pop strobe.
        tx_data_d  = is_scalar_q ? scalar_q : out_bus;
        if (hs) begin
          sum_add   = 1'b1;
          buff_rd_d = !is_scalar_q;
          if (rem_q == LEN_W'(1)) state_d = CSUM;
        end
      end
      CSUM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = csum;
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_scalar_q <= 1'b0;
      scalar_q    <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == CSUM) && hs;
      if (start_ok) begin
        is_scalar_q <= is_scalar;
        scalar_q    <= out_bus;
        len_q       <= start_len;
        rem_q       <= start_len;
        err_q       <= !is_scalar && overflow;
      end else if ((state_q == DATA) && hs) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  assign tx.tx_valid = tx_valid_d;
  assign tx.tx_data  = tx_data_d;
  assign buff_rd     = buff_rd_d;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule : result_framer

// File: tb/tb_result_framer.sv
// Scoreboard bench for result_framer: stimulus pushes the hand-computed frame
// bytes (and whether each should pop the buffer) into a queue; a monitor on
// the falling edge pops and compares every accepted byte.
module tb_result_framer;

  localparam int BITS = 8;
  localparam int N    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_scalar;
  logic [7:0]  out_bus;
  logic [31:0] out_count;
  logic        buff_rd;
  logic        busy;
  logic        done;
  logic        err;

  result_framer_if #(.BITS(BITS)) tx_if ();

  result_framer #(.BITS(BITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_scalar (is_scalar),
    .out_bus   (out_bus),
    .out_count (out_count),
    .buff_rd   (buff_rd),
    .tx        (tx_if.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output buffer model: circular store, head on out_bus, popped by buff_rd
  // or by the bench acting as controller (tb_pop) when draining leftovers.
  logic [7:0] buf_mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       tb_pop = 1'b0;
  logic       drive_scalar = 1'b0;
  logic [7:0] scalar_val = 8'd0;

  assign out_bus   = drive_scalar ? scalar_val : buf_mem[rd_ptr];
  assign out_count = {24'd0, 8'(wr_ptr - rd_ptr)};

  always @(posedge clk) begin
    if (buff_rd || tb_pop) rd_ptr <= rd_ptr + 8'd1;
  end

  typedef struct {
    logic [7:0] data;
    logic       rd;
  } exp_t;

  exp_t exp_q[$];

  // Monitor / scoreboard.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_if.tx_valid, 1'b1);
        check("hold_data", tx_if.tx_data, prev_data);
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", tx_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_if.tx_data, e.data);
          check("buff_rd", buff_rd, e.rd);
        end
      end else begin
        check("buff_rd_idle", buff_rd, 1'b0);
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    buf_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push(input logic [7:0] d, input logic rd);
    exp_t e;
    e.data = d;
    e.rd   = rd;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic scalar);
    start     = 1'b1;
    is_scalar = scalar;
    tick();
    start     = 1'b0;
  endtask

  task automatic expect_frame_start(input string name);
    check({name, "_busy_rise"}, busy, 1'b1);
    check({name, "_valid_rise"}, tx_if.tx_valid, 1'b1);
  endtask

  // Backpressure pattern for tx_ready: 1,0,0,1 repeating.
  function automatic logic bp_ready(input int k);
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  // Waits for done; exp_cycles > 0 checks the edge count after the start edge.
  task automatic wait_done(input string name, input int exp_cycles, input bit bp);
    int  n = 0;
    int  k = 1;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (bp) begin
        tx_if.tx_ready = bp_ready(k);
        k++;
      end
      if (done) begin
        seen = 1'b1;
        if (exp_cycles > 0) check({name, "_latency"}, n, exp_cycles);
        check({name, "_busy_at_done"}, busy, 1'b0);
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (out_count != 0 && guard < 300) begin
      tb_pop = 1'b1;
      tick();
      guard++;
    end
    tb_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    is_scalar      = 1'b0;
    tx_if.tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_tx_valid", tx_if.tx_valid, 1'b0);
    check("rst_tx_data", tx_if.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_buff_rd", buff_rd, 1'b0);
    rst = 1'b0;
    tick();

    // Vector frame 01 02 03.
    load(8'h01); load(8'h02); load(8'h03);
    push(8'h03, 1'b0); push(8'h01, 1'b1); push(8'h02, 1'b1); push(8'h03, 1'b1); push(8'hF7, 1'b0);
    pulse_start(1'b0);
    expect_frame_start("vec");
    wait_done("vec", 5, 1'b0);
    check("vec_drained", out_count, 32'd0);
    tick();

    // Scalar frame; out_bus changes after start and must not leak in.
    drive_scalar = 1'b1;
    scalar_val   = 8'h80;
    push(8'h81, 1'b0); push(8'h80, 1'b0); push(8'hFF, 1'b0);
    pulse_start(1'b1);
    scalar_val = 8'h55;
    expect_frame_start("scalar");
    wait_done("scalar", 3, 1'b0);

    // Empty vector, started in the done cycle of the scalar frame.
    drive_scalar = 1'b0;
    push(8'h00, 1'b0); push(8'h00, 1'b0);
    pulse_start(1'b0);
    check("done_one_cycle", done, 1'b0);
    expect_frame_start("empty");
    wait_done("empty", 2, 1'b0);
    tick();

    // Backpressure: A1 B2 C3 -> 03 A1 B2 C3 E7.
    load(8'hA1); load(8'hB2); load(8'hC3);
    push(8'h03, 1'b0); push(8'hA1, 1'b1); push(8'hB2, 1'b1); push(8'hC3, 1'b1); push(8'hE7, 1'b0);
    tx_if.tx_ready = 1'b1;
    pulse_start(1'b0);
    expect_frame_start("bp");
    wait_done("bp", 0, 1'b1);
    tx_if.tx_ready = 1'b1;
    check("bp_drained", out_count, 32'd0);
    tick();

    // Overflow: 70 bytes 0..69, only 0..63 sent, sum 0x20 -> csum 0xE0.
    for (int i = 0; i < 70; i++) load(8'(i));
    push(8'h40, 1'b0);
    for (int i = 0; i < 64; i++) push(8'(i), 1'b1);
    push(8'hE0, 1'b0);
    pulse_start(1'b0);
    check("ovf_err_set", err, 1'b1);
    expect_frame_start("ovf");
    wait_done("ovf", 66, 1'b0);
    check("ovf_err_sticky", err, 1'b1);
    check("ovf_leftover", out_count, 32'd6);
    drain();

    // Following in-range start clears err: AA 55 -> 02 AA 55 FF.
    load(8'hAA); load(8'h55);
    push(8'h02, 1'b0); push(8'hAA, 1'b1); push(8'h55, 1'b1); push(8'hFF, 1'b0);
    pulse_start(1'b0);
    check("err_cleared", err, 1'b0);
    wait_done("clr", 4, 1'b0);
    tick();

    // Reset while the second data byte is presented (stalled).
    load(8'h10); load(8'h20); load(8'h30);
    push(8'h03, 1'b0); push(8'h10, 1'b1);
    pulse_start(1'b0);          // now in HDR cycle
    tick();                     // first data byte cycle
    tick();                     // second data byte cycle
    check("rst_mid_data", tx_if.tx_data, 8'h20);
    tx_if.tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_mid_valid", tx_if.tx_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    tx_if.tx_ready = 1'b1;
    tick();
    tick();
    check("rst_no_restart", tx_if.tx_valid, 1'b0);
    check("rst_leftover", out_count, 32'd2);
    drain();

    // start while busy is ignored: 77 -> 01 77 88, then nothing more.
    load(8'h77);
    push(8'h01, 1'b0); push(8'h77, 1'b1); push(8'h88, 1'b0);
    tx_if.tx_ready = 1'b0;
    pulse_start(1'b0);
    check("ign_busy", busy, 1'b1);
    pulse_start(1'b0);
    tx_if.tx_ready = 1'b1;
    wait_done("ign", 0, 1'b0);
    repeat (5) tick();
    check("ign_no_second_valid", tx_if.tx_valid, 1'b0);
    check("ign_no_second_busy", busy, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_result_framer
